// File: rtl/cgra_stream_pkg.sv
// cgra_stream_pkg: shared state type and field widths for the CGRA stream engines
package cgra_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stream_state_t;
    localparam int STRIDE_WIDTH = 16;
    localparam int COUNT_WIDTH  = 16;
endpackage

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO, head word on dout (zero while empty), push allowed when full if popping
module stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    // storage needs no reset: empty masks it on dout
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/stream_reader.sv
// stream_reader: strided, credit-limited memory reads streamed out through a FIFO; STREAM_READER_WRAP_EN adds wrap/stop
module stream_reader
    import cgra_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [STRIDE_WIDTH-1:0] stride,
    input  logic [COUNT_WIDTH-1:0]  count,
`ifdef STREAM_READER_WRAP_EN
    input  logic                    wrap,
    input  logic                    stop,
`endif
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_v,
    input  logic                    dout_r,
    output logic                    busy,
    output logic                    done
);
    localparam int CW = $clog2(FIFO_DEPTH);
    stream_state_t state, next_state;
    logic [ADDR_WIDTH-1:0] base_q, step;
    logic [STRIDE_WIDTH-1:0] stride_q;
    logic [COUNT_WIDTH-1:0] count_q, req_cnt;
    logic [CW:0] outstanding, fifo_count;
    logic gnt_fire, last_req, wrap_go, push, pop, last_word, full, empty;
    assign step      = {{(ADDR_WIDTH-STRIDE_WIDTH){stride_q[STRIDE_WIDTH-1]}}, stride_q};
    assign gnt_fire  = mem_req && mem_gnt;
    assign last_req  = req_cnt == count_q - COUNT_WIDTH'(1);
    assign push      = mem_rvalid && outstanding != '0;
    assign pop       = dout_v && dout_r;
    assign dout_v    = !empty;
    assign mem_req   = state == RUN && !full && fifo_count + outstanding < (CW+1)'(FIFO_DEPTH);
    assign last_word = state == DRAIN && pop && outstanding == '0 && fifo_count == (CW+1)'(1);
    assign busy      = state != IDLE;
    assign done      = state == DONE;
`ifdef STREAM_READER_WRAP_EN
    logic stop_q;
    assign wrap_go = wrap && !stop && !stop_q;
    // a stop pulse is held until the next pass boundary
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) stop_q <= 1'b0;
        else if (state == IDLE) stop_q <= 1'b0;
        else if (state == RUN && stop) stop_q <= 1'b1;
`else
    assign wrap_go = 1'b0;
`endif
    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    // next state: the last word leaving the FIFO with nothing in flight ends a drain
    always_comb begin
        next_state = (state == IDLE && start) ? ((count == '0) ? DONE : RUN) :
                     (state == RUN && gnt_fire && last_req && !wrap_go) ? DRAIN :
                     (state == DRAIN && last_word) ? DONE :
                     (state == DONE) ? IDLE : state;
    end
    // config capture, address generation, request count and read credit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            base_q      <= '0;
            mem_addr    <= '0;
            stride_q    <= '0;
            count_q     <= '0;
            req_cnt     <= '0;
            outstanding <= '0;
        end else begin
            if (state == IDLE && start) begin
                base_q   <= base_addr;
                mem_addr <= base_addr;
                stride_q <= stride;
                count_q  <= count;
                req_cnt  <= '0;
            end else if (gnt_fire) begin
                mem_addr <= (wrap_go && last_req) ? base_q : mem_addr + step;
                req_cnt  <= last_req ? '0 : req_cnt + COUNT_WIDTH'(1);
            end
            outstanding <= outstanding + (CW+1)'(gnt_fire) - (CW+1)'(push);
        end
    stream_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (mem_rdata),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
endmodule
